conv_complex_accum: RTL and testbench

Sequential complex accumulator downstream of the fixed-point complex multiplier in the convolution datapath. Accepts one complex product per handshake and sums up to N_TAPS products per frame in a guard-bit-extended accumulator. Saturates the result back to QI+QF format and presents it with sticky error flags on a valid/ready output.

---
 rtl/conv_pkg.sv | 22 ++
 rtl/sat_narrow.sv | 26 ++
 rtl/conv_complex_accum.sv | 93 +++++++++
 tb/tb_conv_complex_accum.sv | 122 ++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared types and width/limit helpers for the convolution datapath
package conv_pkg;

    typedef enum logic {ACC, DONE} state_t;

    function automatic int word_w(input int qi, input int qf);
        return qi + qf;
    endfunction

    function automatic int acc_w(input int w, input int n_taps);
        return w + $clog2(n_taps);
    endfunction

    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/sat_narrow.sv
// sat_narrow: combinational signed clamp from IN_W to OUT_W bits with a saturation flag
module sat_narrow
    import conv_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 6
) (
    input  logic [IN_W-1:0]  value,
    output logic [OUT_W-1:0] result,
    output logic             sat
);

    localparam logic signed [IN_W-1:0] MAX = IN_W'(sat_max(OUT_W));
    localparam logic signed [IN_W-1:0] MIN = IN_W'(sat_min(OUT_W));

    logic hi, lo;

    // clamp to the narrow range; flag whenever either bound is hit
    always_comb begin
        hi     = $signed(value) > MAX;
        lo     = $signed(value) < MIN;
        result = hi ? MAX[OUT_W-1:0] : lo ? MIN[OUT_W-1:0] : value[OUT_W-1:0];
        sat    = hi | lo;
    end

endmodule

// File: rtl/conv_complex_accum.sv
// conv_complex_accum: per-frame complex product accumulator with saturated, flagged result
module conv_complex_accum
    import conv_pkg::*;
#(
    parameter int QI     = 3,
    parameter int QF     = 3,
    parameter int N_TAPS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [QI+QF-1:0]             in_Re,
    input  logic [QI+QF-1:0]             in_Im,
    input  logic                         in_overflow,
    input  logic                         in_bad_rep,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [QI+QF-1:0]             out_Re,
    output logic [QI+QF-1:0]             out_Im,
    output logic                         out_sat,
    output logic                         out_flag,
    output logic [$clog2(N_TAPS+1)-1:0]  out_count
);

    localparam int W  = word_w(QI, QF);
    localparam int AW = acc_w(W, N_TAPS);
    localparam int CW = $clog2(N_TAPS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N_TAPS - 1);

    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [AW-1:0] acc_re, acc_im, sum_re, sum_im;
    logic [W-1:0] sat_re, sat_im;
    logic sr, si, flag, flag_nx, accept, frame_end;

    assign in_ready  = (state == ACC) && !rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign frame_end = accept & (in_last | (cnt == LAST_CNT));

    // first beat of a frame starts from zero so a stale accumulator never leaks in
    always_comb begin
        sum_re  = (cnt == '0 ? '0 : acc_re) + {{(AW-W){in_Re[W-1]}}, in_Re};
        sum_im  = (cnt == '0 ? '0 : acc_im) + {{(AW-W){in_Im[W-1]}}, in_Im};
        flag_nx = (cnt == '0 ? 1'b0 : flag) | in_overflow | in_bad_rep;
    end

    sat_narrow #(.IN_W(AW), .OUT_W(W)) u_sat_re (.value(sum_re), .result(sat_re), .sat(sr));
    sat_narrow #(.IN_W(AW), .OUT_W(W)) u_sat_im (.value(sum_im), .result(sat_im), .sat(si));

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACC;
        else     state <= state_nx;
    end

    // collect until the frame closes, then hold until the consumer takes the result
    always_comb begin
        state_nx = state;
        if (state == ACC) state_nx = frame_end ? DONE : ACC;
        else              state_nx = out_ready ? ACC : DONE;
    end

    // accumulators, counter and flag; the closing beat also loads the output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            acc_re    <= '0;
            acc_im    <= '0;
            flag      <= 1'b0;
            out_Re    <= '0;
            out_Im    <= '0;
            out_sat   <= 1'b0;
            out_flag  <= 1'b0;
            out_count <= '0;
        end else if (accept) begin
            acc_re <= sum_re;
            acc_im <= sum_im;
            flag   <= flag_nx;
            cnt    <= frame_end ? '0 : cnt + 1'b1;
            if (frame_end) begin
                out_Re    <= sat_re;
                out_Im    <= sat_im;
                out_sat   <= sr | si;
                out_flag  <= flag_nx;
                out_count <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_complex_accum.sv
// tb_conv_complex_accum: directed self-checking bench for conv_complex_accum
module tb_conv_complex_accum;

    logic clk, rst, in_valid, in_ready, in_overflow, in_bad_rep, in_last;
    logic out_valid, out_ready, out_sat, out_flag;
    logic [5:0] in_Re, in_Im, out_Re, out_Im;
    logic [2:0] out_count;
    int n_cmp, n_bad;

    conv_complex_accum dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_Re(in_Re), .in_Im(in_Im),
        .in_overflow(in_overflow), .in_bad_rep(in_bad_rep), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_Re(out_Re), .out_Im(out_Im),
        .out_sat(out_sat), .out_flag(out_flag), .out_count(out_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    task automatic beat(input int re, input int im, input bit last, input bit ovf, input bit bad);
        in_valid = 1; in_Re = 6'(re); in_Im = 6'(im);
        in_last = last; in_overflow = ovf; in_bad_rep = bad;
        @(posedge clk); #1;
        in_valid = 0; in_last = 0; in_overflow = 0; in_bad_rep = 0;
    endtask

    task automatic result(input string tag, input int re, input int im, input int cnt, input int sat, input int flag);
        check({tag, " valid"}, int'(out_valid), 1);
        check({tag, " ready"}, int'(in_ready), 0);
        check({tag, " re"}, int'($signed(out_Re)), re);
        check({tag, " im"}, int'($signed(out_Im)), im);
        check({tag, " count"}, int'(out_count), cnt);
        check({tag, " sat"}, int'(out_sat), sat);
        check({tag, " flag"}, int'(out_flag), flag);
    endtask

    task automatic ack(input string tag);
        in_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        check({tag, " ack valid"}, int'(out_valid), 0);
        check({tag, " ack ready"}, int'(in_ready), 1);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1; in_valid = 0; in_Re = 0; in_Im = 0;
        in_last = 0; in_overflow = 0; in_bad_rep = 0; out_ready = 0;
        repeat (2) @(posedge clk); #1;
        check("rst valid", int'(out_valid), 0);
        check("rst ready", int'(in_ready), 0);
        check("rst re", int'(out_Re), 0);
        check("rst count", int'(out_count), 0);
        rst = 0; #1;
        check("post rst ready", int'(in_ready), 1);

        for (int i = 0; i < 4; i++) beat(4, -2, 0, 0, 0);
        result("basic", 16, -8, 4, 0, 0);
        ack("basic");

        for (int i = 0; i < 4; i++) beat(24, -32, 0, 0, 0);
        result("sat", 31, -32, 4, 1, 0);
        ack("sat");

        beat(8, 0, 0, 0, 0);
        beat(8, 0, 1, 0, 0);
        result("early", 16, 0, 2, 0, 0);
        ack("early");

        for (int i = 0; i < 4; i++) beat(2, -1, 0, 0, 0);
        result("fresh", 8, -4, 4, 0, 0);
        in_valid = 1; in_Re = 6'd7; in_Im = 6'd7;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            result("hold", 8, -4, 4, 0, 0);
        end
        ack("hold");

        for (int i = 0; i < 4; i++) beat(1, 3, 0, i == 1, 0);
        result("ovf", 4, 12, 4, 0, 1);
        ack("ovf");

        for (int i = 0; i < 4; i++) beat(1, 0, 0, 0, 0);
        result("clean", 4, 0, 4, 0, 0);
        ack("clean");

        beat(-5, 7, 1, 0, 1);
        result("single", -5, 7, 1, 0, 1);
        ack("single");

        beat(3, 3, 0, 0, 0);
        beat(3, 3, 0, 0, 0);
        #2 rst = 1; #1;
        check("arst valid", int'(out_valid), 0);
        check("arst ready", int'(in_ready), 0);
        check("arst re", int'(out_Re), 0);
        check("arst im", int'(out_Im), 0);
        check("arst flag", int'(out_flag), 0);
        check("arst sat", int'(out_sat), 0);
        check("arst count", int'(out_count), 0);
        @(posedge clk); #1;
        rst = 0; #1;
        for (int i = 0; i < 4; i++) beat(1, 0, 0, 0, 0);
        result("after rst", 4, 0, 4, 0, 0);
        ack("after rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
